// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises the raw active-low key, filters contact bounce,
// and classifies presses into press/release/click/long-press events plus a press counter.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    output logic       key_level,
    output logic       press_p,
    output logic       release_p,
    output logic       click_p,
    output logic       long_p,
    output logic [7:0] press_cnt
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
        end
        if (LONG_CYCLES < 1) begin : g_bad_long
            $error("key_debounce: LONG_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        RELEASED,
        PRESSED,
        LONG_HELD
    } state_t;

    state_t            state;
    logic [1:0]        sync;
    logic              k_s;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              disagree;
    logic              accept;

    assign k_s = sync[1];

    // k_s is active-low; key_level is active-high, so they disagree when equal.
    always_comb begin
        disagree = (k_s == key_level);
        accept   = disagree && (db_cnt == DB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
        end else if (!disagree || accept) begin
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RELEASED;
            key_level <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
            click_p   <= 1'b0;
            long_p    <= 1'b0;
            press_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            press_p   <= 1'b0;
            release_p <= 1'b0;
            click_p   <= 1'b0;
            long_p    <= 1'b0;

            case (state)
                RELEASED: begin
                    if (accept) begin
                        state     <= PRESSED;
                        key_level <= 1'b1;
                        press_p   <= 1'b1;
                        press_cnt <= press_cnt + 8'd1;
                        hold_cnt  <= '0;
                    end
                end

                // Release acceptance is checked first so it beats a coincident long threshold.
                PRESSED: begin
                    if (accept) begin
                        state     <= RELEASED;
                        key_level <= 1'b0;
                        release_p <= 1'b1;
                        click_p   <= 1'b1;
                    end else begin
                        if (hold_cnt != HOLD_MAX) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                        if (hold_cnt == HOLD_LAST) begin
                            state  <= LONG_HELD;
                            long_p <= 1'b1;
                        end
                    end
                end

                LONG_HELD: begin
                    if (accept) begin
                        state     <= RELEASED;
                        key_level <= 1'b0;
                        release_p <= 1'b1;
                    end
                end

                default: begin
                    state     <= RELEASED;
                    key_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulse events are queued with the cycle they
// must appear in, and a negedge monitor matches every observed pulse against the queue.
module tb_key_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int unsigned LAT  = DEB + 2;

    // Event encoding: {press_p, release_p, click_p, long_p}
    localparam logic [3:0] EV_PRESS     = 4'b1000;
    localparam logic [3:0] EV_REL       = 4'b0100;
    localparam logic [3:0] EV_REL_CLICK = 4'b0110;
    localparam logic [3:0] EV_LONG      = 4'b0001;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  ev;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       key_level;
    logic       press_p;
    logic       release_p;
    logic       click_p;
    logic       long_p;
    logic [7:0] press_cnt;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    logic [7:0]  model_cnt = '0;
    exp_t        q[$];
    exp_t        mon_e;
    logic [3:0]  mon_obs;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .key_level(key_level),
        .press_p  (press_p),
        .release_p(release_p),
        .click_p  (click_p),
        .long_p   (long_p),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_obs = {press_p, release_p, click_p, long_p};
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event: ev=%b due at cycle %0d never seen (now %0d)",
                         q[0].ev, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (mon_obs != 4'b0000 || (q.size() > 0 && q[0].cyc == cyc)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got ev=%b at cycle %0d, required none",
                             mon_obs, cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mon_obs !== mon_e.ev) begin
                        errors++;
                        $display("FAIL event: got ev=%b at cycle %0d, required ev=%b at cycle %0d",
                                 mon_obs, cyc, mon_e.ev, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic expect_ev(input int unsigned at, input logic [3:0] ev);
        exp_t e;
        e.cyc = at;
        e.ev  = ev;
        q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 1'b1;
        #1;
        checks++;
        if ({key_level, press_p, release_p, click_p, long_p} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {key_level, press_p, release_p, click_p, long_p});
        end
        checks++;
        if (press_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d required 0", press_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL idle_level: got %b required 0", key_level);
        end
    endtask

    task automatic test_clean_press();
        int unsigned c;
        @(negedge clk);
        c = cyc;
        key_n = 1'b0;
        expect_ev(c + LAT, EV_PRESS);
        model_cnt++;
        repeat (LAT - 1) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL clean_early_level: got %b required 0", key_level);
        end
        @(negedge clk);
        checks++;
        if (key_level !== 1'b1) begin
            errors++;
            $display("FAIL clean_level: got %b required 1", key_level);
        end
        checks++;
        if (press_cnt !== model_cnt) begin
            errors++;
            $display("FAIL clean_cnt: got %0d required %0d", press_cnt, model_cnt);
        end
        repeat (4) @(negedge clk);
        c = cyc;
        key_n = 1'b1;
        expect_ev(c + LAT, EV_REL_CLICK);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_level: got %b required 0", key_level);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL clean_drain: got %0d pending events required 0", q.size());
        end
    endtask

    task automatic test_bounce();
        int unsigned c;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_level: got %b required 0", key_level);
        end
        c = cyc;
        key_n = 1'b0;
        expect_ev(c + LAT, EV_PRESS);
        model_cnt++;
        repeat (LAT) @(negedge clk);
        checks++;
        if (press_cnt !== model_cnt) begin
            errors++;
            $display("FAIL bounce_cnt: got %0d required %0d", press_cnt, model_cnt);
        end
        @(negedge clk);
        c = cyc;
        key_n = 1'b1;
        expect_ev(c + LAT, EV_REL_CLICK);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL bounce_drain: got %0d pending events required 0", q.size());
        end
    endtask

    task automatic test_short_click();
        int unsigned c;
        @(negedge clk);
        c = cyc;
        key_n = 1'b0;
        expect_ev(c + LAT, EV_PRESS);
        model_cnt++;
        repeat (LAT) @(negedge clk);
        repeat (10) @(negedge clk);
        c = cyc;
        key_n = 1'b1;
        expect_ev(c + LAT, EV_REL_CLICK);
        repeat (LAT) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL short_level: got %b required 0", key_level);
        end
        repeat (LONG + 5) @(negedge clk);
        checks++;
        if (press_cnt !== model_cnt) begin
            errors++;
            $display("FAIL short_cnt: got %0d required %0d", press_cnt, model_cnt);
        end
    endtask

    task automatic test_long_press();
        int unsigned c;
        int unsigned p;
        @(negedge clk);
        c = cyc;
        key_n = 1'b0;
        expect_ev(c + LAT, EV_PRESS);
        expect_ev(c + LAT + LONG, EV_LONG);
        model_cnt++;
        repeat (LAT) @(negedge clk);
        p = cyc;
        repeat (LONG + 10) @(negedge clk);
        checks++;
        if (key_level !== 1'b1) begin
            errors++;
            $display("FAIL long_level: got %b required 1", key_level);
        end
        repeat (40 - LONG - 10) @(negedge clk);
        c = cyc;
        key_n = 1'b1;
        expect_ev(c + LAT, EV_REL);
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL long_release_level: got %b required 0 (pressed at %0d)", key_level, p);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL long_drain: got %0d pending events required 0", q.size());
        end
    endtask

    // Release acceptance lands on the same edge as the long threshold.
    task automatic test_release_vs_long();
        int unsigned c;
        @(negedge clk);
        c = cyc;
        key_n = 1'b0;
        expect_ev(c + LAT, EV_PRESS);
        model_cnt++;
        repeat (LONG) @(negedge clk);
        key_n = 1'b1;
        expect_ev(c + LONG + LAT, EV_REL_CLICK);
        repeat (LAT + 20) @(negedge clk);
        checks++;
        if (key_level !== 1'b0) begin
            errors++;
            $display("FAIL tie_level: got %b required 0", key_level);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL tie_drain: got %0d pending events required 0", q.size());
        end
    endtask

    task automatic test_reset_mid_press();
        int unsigned c;
        @(negedge clk);
        c = cyc;
        key_n = 1'b0;
        expect_ev(c + LAT, EV_PRESS);
        expect_ev(c + LAT + LONG, EV_LONG);
        model_cnt++;
        repeat (LAT + LONG + 4) @(negedge clk);
        rst_n = 1'b0;
        model_cnt = '0;
        #1;
        checks++;
        if ({key_level, press_p, release_p, click_p, long_p} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b required 00000",
                     {key_level, press_p, release_p, click_p, long_p});
        end
        checks++;
        if (press_cnt !== model_cnt) begin
            errors++;
            $display("FAIL midreset_cnt: got %0d required %0d", press_cnt, model_cnt);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL midreset_drain: got %0d pending events required 0", q.size());
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        expect_ev(c + LAT, EV_PRESS);
        model_cnt++;
        repeat (LAT) @(negedge clk);
        checks++;
        if (press_cnt !== model_cnt) begin
            errors++;
            $display("FAIL midreset_repress_cnt: got %0d required %0d", press_cnt, model_cnt);
        end
        checks++;
        if (key_level !== 1'b1) begin
            errors++;
            $display("FAIL midreset_level: got %b required 1", key_level);
        end
        repeat (4) @(negedge clk);
        c = cyc;
        key_n = 1'b1;
        expect_ev(c + LAT, EV_REL_CLICK);
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic test_counter_wrap();
        int unsigned c;
        @(negedge clk);
        rst_n = 1'b0;
        model_cnt = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            c = cyc;
            key_n = 1'b0;
            expect_ev(c + LAT, EV_PRESS);
            model_cnt++;
            repeat (LAT) @(negedge clk);
            checks++;
            if (press_cnt !== model_cnt) begin
                errors++;
                $display("FAIL wrap_cnt: press %0d got %0d required %0d", i, press_cnt, model_cnt);
            end
            @(negedge clk);
            c = cyc;
            key_n = 1'b1;
            expect_ev(c + LAT, EV_REL_CLICK);
            repeat (LAT + 2) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_short_click();
        test_long_press();
        test_release_vs_long();
        test_reset_mid_press();
        test_counter_wrap();
        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: got %0d pending events required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces and classifies one mechanical push-button on the input side of the FPGA, complementing the LED blink drivers on the output side. Synchronises the raw active-low key into `clk`, filters contact bounce with a consecutive-sample counter, and produces a clean level plus single-cycle press, release, click and long-press events and a press counter for downstream control logic.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive agreeing samples required to accept a level change; legal range ≥ 2.
- `LONG_CYCLES`, default 50_000_000 (1 s at 50 MHz): held duration, counted from `press_p`, that qualifies as a long press; legal range ≥ 1.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_n` input 1: raw button, asynchronous to `clk`; 0 = pressed.
- `key_level` output 1: debounced level; 1 = pressed.
- `press_p` output 1: one-cycle pulse when a press is accepted.
- `release_p` output 1: one-cycle pulse when a release is accepted.
- `click_p` output 1: one-cycle pulse with `release_p` when `long_p` did not fire for this press.
- `long_p` output 1: one-cycle pulse when a press has been held `LONG_CYCLES`.
- `press_cnt` output 8: number of accepted presses, modulo 256.

## Operation
- Synchroniser: two flops on `key_n`, both reset to 1 (released). Synchronised output `k_s` is the only signal the FSM samples.
- Debounce counter `db_cnt`, width `$clog2(DEBOUNCE_CYCLES)`: increments on each edge where `k_s` disagrees with `key_level`; clears to 0 on any edge where it agrees. On the edge where it would reach `DEBOUNCE_CYCLES`, the level change is accepted and `db_cnt` clears.
- Hold counter `hold_cnt`, width `$clog2(LONG_CYCLES+1)`: clears on press acceptance, increments every cycle in PRESSED, saturates; stops in LONG_HELD.
- FSM states:
  - RELEASED: `key_level`=0. Press accepted -> PRESSED; `press_p`=1; `press_cnt`+1.
  - PRESSED: `key_level`=1. Release accepted -> RELEASED; `release_p`=1, `click_p`=1. Otherwise, `hold_cnt` reaches `LONG_CYCLES` -> LONG_HELD; `long_p`=1.
  - LONG_HELD: `key_level`=1. Release accepted -> RELEASED; `release_p`=1, `click_p`=0.
- Simultaneous release acceptance and long threshold on the same edge: release wins; `release_p` and `click_p` assert, `long_p` does not.
- `hold_cnt` keeps counting while a release is pending, i.e. during bounce with `db_cnt` > 0.
- `press_cnt` wraps 255 -> 0 silently.
- All outputs are registered.

## Timing
- Reset (`rst_n`=0, asynchronous): state RELEASED. `key_level`, `press_p`, `release_p`, `click_p`, `long_p` = 0. `press_cnt`, `db_cnt`, `hold_cnt` = 0. Synchroniser flops = 1.
- Reset mid-press discards the press. A key still held at deassertion is re-debounced from scratch, with no `release_p` emitted.
- Latency: raw `key_n` stable change, then first rising edge = edge 1. `k_s` updates at edge 2. Acceptance at edge `DEBOUNCE_CYCLES`+2. Pulse and `key_level` change are visible in the cycle after that edge.
- Any disagreement gap (bounce) restarts the `DEBOUNCE_CYCLES` window.
- `long_p` asserts exactly `LONG_CYCLES` cycles after the `press_p` cycle.
- Every pulse output is high for exactly one cycle per event. At most one of `press_p` / `release_p` is high in any cycle.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.
- Clean press: `key_n` 1->0 and held -> `press_p` high for one cycle after edge 6; `key_level`=1 from then; `press_cnt`=1; no other pulses.
- Bounce: `key_n` toggles every 2 cycles for 20 cycles, then stays 0 -> no pulses during the toggling; a single `press_p` after the 6th edge following the last fall.
- Short click: press accepted, hold 10 cycles, release -> `release_p` and `click_p` both high in the same single cycle, 6 edges after the rise; `long_p` never asserts.
- Long press: hold 40 cycles -> `long_p` exactly 20 cycles after `press_p`; on release, `release_p`=1 with `click_p`=0.
- Reset mid-press: `rst_n`=0 while in LONG_HELD -> all outputs 0 immediately and `press_cnt`=0. Deassert with the key held -> `press_p` after 6 edges; no `release_p`.
- Counter wrap: 256 clean clicks -> `press_cnt` reads 255 after the 255th press and 0 after the 256th.
